// File: rtl/boot_jump_ctrl.sv
// Boot-time jump-on-reset sequencer and memory-map control register.
// After reset it phantoms the first three memory reads and returns the
// bytes of JP {JUMP_HI,JUMP_LO}, so the CPU vectors into the ROM window.
// It also holds the romDisable/vRamEn enables for the address decoder.
module boot_jump_ctrl #(
   parameter logic [7:0] JUMP_LO   = 8'h00,
   parameter logic [7:0] JUMP_HI   = 8'hF0,
   parameter logic [7:0] CTRL_PORT = 8'h3F,
   parameter logic       VRAM_RST  = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       memread,
   input  logic       iowrite,
   input  logic       ioread,
   input  logic [7:0] io_addr,
   input  logic [7:0] data_in,
   output logic       n_jorphant,
   output logic [7:0] jump_data,
   output logic       jump_oe,
   output logic       romDisable,
   output logic       vRamEn,
   output logic [7:0] ctrl_rdata,
   output logic       ctrl_rd_sel
);

   localparam logic [7:0] OP_JP    = 8'hC3;
   localparam logic [7:0] RUN_DATA = 8'h00;

   typedef enum logic [1:0] {
      ST_J0,
      ST_J1,
      ST_J2,
      ST_RUN
   } state_t;

   state_t     r_state;
   logic [7:0] r_jump_data;
   logic       r_n_jorphant;
   logic       r_memread_d;
   logic       r_iowrite_d;
   logic       r_rom_disable;
   logic       r_vram_en;

   logic       w_rd_end;
   logic       w_wr_stb;
   logic       w_ctrl_wr;
   logic       w_unused_data;

   // A multi-clock read counts once, on its falling edge; a held write fires once.
   assign w_rd_end  = r_memread_d & ~memread;
   assign w_wr_stb  = iowrite & ~r_iowrite_d;
   assign w_ctrl_wr = w_wr_stb & (io_addr == CTRL_PORT);

   // Only the two low data bits land in the control register.
   assign w_unused_data = ^data_in[7:2];

   // One-clock delayed copies of the bus strobes for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_memread_d <= 1'b0;
         r_iowrite_d <= 1'b0;
      end else begin
         r_memread_d <= memread;
         r_iowrite_d <= iowrite;
      end
   end

   // Phantom sequencer: steps J0->J1->J2->RUN on each completed read.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_J0;
         r_jump_data  <= OP_JP;
         r_n_jorphant <= 1'b0;
      end else if (w_rd_end) begin
         case (r_state)
            ST_J0: begin
               r_state     <= ST_J1;
               r_jump_data <= JUMP_LO;
            end
            ST_J1: begin
               r_state     <= ST_J2;
               r_jump_data <= JUMP_HI;
            end
            ST_J2: begin
               r_state      <= ST_RUN;
               r_jump_data  <= RUN_DATA;
               r_n_jorphant <= 1'b1;
            end
            default: begin
               r_state      <= ST_RUN;
               r_jump_data  <= RUN_DATA;
               r_n_jorphant <= 1'b1;
            end
         endcase
      end
   end

   // Memory-map control register, independent of the phantom sequence.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rom_disable <= 1'b1;
         r_vram_en     <= VRAM_RST;
      end else if (w_ctrl_wr) begin
         r_rom_disable <= data_in[0];
         r_vram_en     <= data_in[1];
      end
   end

   assign n_jorphant  = r_n_jorphant;
   assign jump_data   = r_jump_data;
   assign jump_oe     = ~r_n_jorphant & memread;
   assign romDisable  = r_rom_disable;
   assign vRamEn      = r_vram_en;
   assign ctrl_rdata  = {6'b0, r_vram_en, r_rom_disable};
   assign ctrl_rd_sel = ioread & (io_addr == CTRL_PORT);

endmodule

// File: tb/tb_boot_jump_ctrl.sv
// Scoreboard bench for boot_jump_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares when the DUT serves a read.
module tb_boot_jump_ctrl;

   localparam logic [7:0] CTRL_PORT = 8'h3F;

   logic       clock;
   logic       reset;
   logic       memread;
   logic       iowrite;
   logic       ioread;
   logic [7:0] io_addr;
   logic [7:0] data_in;
   logic       n_jorphant;
   logic [7:0] jump_data;
   logic       jump_oe;
   logic       romDisable;
   logic       vRamEn;
   logic [7:0] ctrl_rdata;
   logic       ctrl_rd_sel;

   boot_jump_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .memread    (memread),
      .iowrite    (iowrite),
      .ioread     (ioread),
      .io_addr    (io_addr),
      .data_in    (data_in),
      .n_jorphant (n_jorphant),
      .jump_data  (jump_data),
      .jump_oe    (jump_oe),
      .romDisable (romDisable),
      .vRamEn     (vRamEn),
      .ctrl_rdata (ctrl_rdata),
      .ctrl_rd_sel(ctrl_rd_sel)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] data;
      logic       oe;
      logic       nj;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] ctrl_q[$];

   int checks   = 0;
   int failures = 0;

   // Reference model: completed reads since reset and the two enables.
   int   mdl_reads;
   logic mdl_rom;
   logic mdl_vram;

   function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Bytes returned by the n-th read after reset: JP target, then normal memory.
   function automatic rd_exp_t exp_for(int n);
      logic [7:0] seq [3];
      rd_exp_t e;
      seq[0] = 8'hC3;
      seq[1] = 8'h00;
      seq[2] = 8'hF0;
      if (n < 3) begin
         e.data = seq[n];
         e.oe   = 1'b1;
         e.nj   = 1'b0;
      end else begin
         e.data = 8'h00;
         e.oe   = 1'b0;
         e.nj   = 1'b1;
      end
      return e;
   endfunction

   // Monitor
   logic    prev_rd = 1'b0;
   logic    prev_cs = 1'b0;
   logic    have_rd = 1'b0;
   rd_exp_t cur;
   logic [7:0] cur_ctrl;

   always @(negedge clock) begin
      logic act;
      act = memread && !reset;
      if (act && !prev_rd) begin
         if (rd_q.size() == 0) begin
            have_rd = 1'b0;
            chk("rd_unexpected", 8'(1), 8'(0));
         end else begin
            cur = rd_q.pop_front();
            have_rd = 1'b1;
         end
      end
      if (act && have_rd) begin
         chk("rd_oe", 8'(jump_oe), 8'(cur.oe));
         chk("rd_data", jump_data, cur.data);
         chk("rd_nj", 8'(n_jorphant), 8'(cur.nj));
      end
      if (!memread && !reset)
         chk("oe_idle", 8'(jump_oe), 8'(0));
      prev_rd = act;

      if (ctrl_rd_sel && !prev_cs) begin
         if (ctrl_q.size() == 0) begin
            chk("ctrl_unexpected", 8'(1), 8'(0));
         end else begin
            cur_ctrl = ctrl_q.pop_front();
            chk("ctrl_rdata", ctrl_rdata, cur_ctrl);
            chk("ctrl_outs", 8'({vRamEn, romDisable}), cur_ctrl);
         end
      end
      prev_cs = ctrl_rd_sel;
   end

   task automatic do_reset(input logic mr);
      @(posedge clock); #1;
      reset   = 1'b1;
      memread = mr;
      repeat (2) @(posedge clock);
      mdl_reads = 0;
      mdl_rom   = 1'b1;
      mdl_vram  = 1'b0;
      if (mr) rd_q.push_back(exp_for(mdl_reads));
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_nj", 8'(n_jorphant), 8'(0));
      chk("rst_data", jump_data, 8'hC3);
      chk("rst_ctrl", ctrl_rdata, {6'b0, mdl_vram, mdl_rom});
      if (mr) begin
         repeat (2) @(posedge clock);
         #1 memread = 1'b0;
         mdl_reads = 1;
         repeat (2) @(negedge clock);
      end
   endtask

   task automatic do_read(input int n);
      int old;
      old = mdl_reads;
      rd_q.push_back(exp_for(mdl_reads));
      @(posedge clock); #1 memread = 1'b1;
      repeat (n) @(posedge clock);
      #1 memread = 1'b0;
      if (mdl_reads < 3) mdl_reads++;
      @(negedge clock);
      chk("nj_pre", 8'(n_jorphant), 8'(old >= 3));
      @(negedge clock);
      chk("nj_post", 8'(n_jorphant), 8'(mdl_reads >= 3));
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] d2, input int hold);
      logic pr, pv;
      pr = mdl_rom;
      pv = mdl_vram;
      @(posedge clock); #1;
      io_addr = a;
      data_in = d;
      iowrite = 1'b1;
      if (a == CTRL_PORT) begin
         mdl_rom  = d[0];
         mdl_vram = d[1];
      end
      @(negedge clock);
      chk("wr_pre", 8'({pv, pr}), 8'({vRamEn, romDisable}));
      @(negedge clock);
      chk("wr_post", 8'({vRamEn, romDisable}), 8'({mdl_vram, mdl_rom}));
      repeat (hold) @(posedge clock);
      #1 data_in = d2;
      repeat (hold) @(posedge clock);
      @(negedge clock);
      chk("wr_hold", 8'({vRamEn, romDisable}), 8'({mdl_vram, mdl_rom}));
      @(posedge clock); #1 iowrite = 1'b0;
   endtask

   // Read completion and control write land on the same clock.
   task automatic do_read_wr(input int n, input logic [7:0] a, input logic [7:0] d);
      int old;
      logic pr, pv;
      old = mdl_reads;
      pr  = mdl_rom;
      pv  = mdl_vram;
      rd_q.push_back(exp_for(mdl_reads));
      @(posedge clock); #1 memread = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      memread = 1'b0;
      iowrite = 1'b1;
      io_addr = a;
      data_in = d;
      if (mdl_reads < 3) mdl_reads++;
      if (a == CTRL_PORT) begin
         mdl_rom  = d[0];
         mdl_vram = d[1];
      end
      @(negedge clock);
      chk("both_pre_nj", 8'(n_jorphant), 8'(old >= 3));
      chk("both_pre_ctrl", 8'({vRamEn, romDisable}), 8'({pv, pr}));
      @(negedge clock);
      chk("both_post_nj", 8'(n_jorphant), 8'(mdl_reads >= 3));
      chk("both_post_ctrl", 8'({vRamEn, romDisable}), 8'({mdl_vram, mdl_rom}));
      @(posedge clock); #1 iowrite = 1'b0;
   endtask

   task automatic do_ctrl_rd(input logic [7:0] a);
      if (a == CTRL_PORT) ctrl_q.push_back({6'b0, mdl_vram, mdl_rom});
      @(posedge clock); #1;
      io_addr = a;
      ioread  = 1'b1;
      repeat (2) @(posedge clock);
      #1 ioread = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      memread = 1'b0;
      iowrite = 1'b0;
      ioread  = 1'b0;
      io_addr = 8'h00;
      data_in = 8'h00;
      mdl_reads = 0;
      mdl_rom   = 1'b1;
      mdl_vram  = 1'b0;

      // Basic phantom sequence and RUN behaviour
      do_reset(1'b0);
      repeat (3) do_read(3);
      do_read(3);
      do_write(8'h3F, 8'h02, 8'h02, 1);
      do_ctrl_rd(8'h3F);
      do_write(8'h3E, 8'h03, 8'h03, 1);
      do_ctrl_rd(8'h3F);
      do_write(8'h3F, 8'h01, 8'h00, 5);
      do_ctrl_rd(8'h3F);
      do_ctrl_rd(8'h3E);

      // Reset in J1, then a full sequence again
      do_reset(1'b0);
      do_read(2);
      do_write(8'h3F, 8'h02, 8'h01, 2);
      do_reset(1'b0);
      do_ctrl_rd(8'h3F);
      repeat (3) do_read(1);

      // Read already in progress across reset release
      do_reset(1'b1);
      do_read(3);
      do_read(2);
      do_read(2);

      // Randomised mix
      for (int i = 0; i < 60; i++) begin
         int op;
         logic [7:0] a, d, d2;
         op = $urandom_range(0, 9);
         a  = ($urandom_range(0, 1) == 0) ? CTRL_PORT : 8'($urandom);
         d  = 8'($urandom);
         d2 = 8'($urandom);
         case (op)
            0, 1, 2, 3: do_read($urandom_range(1, 4));
            4, 5:       do_write(a, d, d2, $urandom_range(1, 3));
            6, 7:       do_ctrl_rd(a);
            8:          do_read_wr($urandom_range(1, 3), a, d);
            default:    do_reset(1'($urandom_range(0, 1)));
         endcase
      end

      repeat (5) @(posedge clock);
      @(negedge clock);
      chk("rd_q_drained", 8'(rd_q.size()), 8'(0));
      chk("ctrl_q_drained", 8'(ctrl_q.size()), 8'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boot_jump_ctrl.md
Name: boot_jump_ctrl

Overview:
- Boot-time jump-on-reset sequencer and memory-map control register for the S100 Z80 FPGA SBC.
- After reset, it "phantoms" the first three memory reads and supplies the opcode bytes JP F000h, so the Z80 vectors into the ROM window.
- It holds the romDisable and vRamEn enables that configure the memory address decoder downstream.
- It drives n_jorphant directly into that decoder.

Parameters:
- JUMP_LO, 8'h00, low byte of jump target.
- JUMP_HI, 8'hF0, high byte of jump target (ROM base).
- CTRL_PORT, 8'h3F, I/O port address of the control register.
- VRAM_RST, 1'b0, reset value of vRamEn.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset, sampled on rising edge of clock.
- memread  in  1  CPU memory read active (level, spans several clocks).
- iowrite  in  1  CPU I/O write active (level).
- ioread  in  1  CPU I/O read active (level).
- io_addr  in  8  low I/O address byte.
- data_in  in  8  CPU data bus out.
- n_jorphant  out  1  low = phantom active; decoder must deselect RAM.
- jump_data  out  8  opcode/operand byte to present on the CPU data-in bus.
- jump_oe  out  1  high = mux jump_data onto the CPU data-in bus.
- romDisable  out  1  ROM enable to decoder; 1 = ROM visible at F000h-FFFFh.
- vRamEn  out  1  1 = VGA RAM decoded at E000h-EFFFh.
- ctrl_rdata  out  8  control register readback {6'b0, vRamEn, romDisable}.
- ctrl_rd_sel  out  1  ioread && io_addr==CTRL_PORT (combinational).

Behaviour:
- All state is updated on the rising edge of clock. Reset is synchronous and overrides everything.
- Reset values:
  - state=J0, n_jorphant=0.
  - romDisable=1, vRamEn=VRAM_RST.
  - memread_d=0, iowrite_d=0.
- Edge detection, from one-clock-delayed copies:
  - rd_end = memread_d & !memread (falling edge: read complete).
  - wr_stb = iowrite & !iowrite_d (rising edge).
- State machine:
  - J0: jump_data=8'hC3. On rd_end go to J1.
  - J1: jump_data=JUMP_LO. On rd_end go to J2.
  - J2: jump_data=JUMP_HI. On rd_end go to RUN.
  - RUN: terminal state; jump_data=8'h00. Left only via reset.
- n_jorphant is registered and low in J0/J1/J2. It goes high on the same edge that enters RUN, i.e. one clock after memread falls on the third read.
- jump_oe = !n_jorphant & memread (combinational). It is never asserted outside a read.
- Reads while memread is held high do not advance the state. Only the falling edge counts, so each multi-clock Z80 read counts once.
- A memread already high when reset deasserts counts as read 0; its falling edge advances J0 to J1.
- Control register:
  - Written on wr_stb with io_addr==CTRL_PORT: romDisable<=data_in[0], vRamEn<=data_in[1]. data_in[7:2] are ignored.
  - The write takes effect on the clock after the iowrite rising edge.
  - Writes are accepted in any state, including during the phantom.
  - Writes to other port addresses have no effect.
  - An iowrite held high causes one write only.
- Simultaneous rd_end and wr_stb: both take effect in the same clock; they are independent.
- Reset mid-sequence (any state): returns to J0 with n_jorphant=0. The next three reads are phantomed again, and the control register returns to reset values.
- ctrl_rdata is always valid. ctrl_rd_sel gates it onto the CPU data-in mux; priority of jump_oe over ctrl_rd_sel is irrelevant because they are mutually exclusive by bus cycle type.
- Latency summary: control-register write to output is 1 clock; third-read end to n_jorphant high is 1 clock.

Test Plan:
- Reset, then three memread pulses of 3 clocks each -> jump_data C3, 00, F0 with jump_oe high during each pulse. n_jorphant=0 throughout, then rises 1 clk after the third fall.
- Fourth memread after RUN -> jump_oe=0, n_jorphant=1, state stays RUN.
- In RUN: iowrite to 3Fh with data 8'h02 -> romDisable=0, vRamEn=1 next clock, ctrl_rdata=8'h02. iowrite to 3Eh with 8'h03 -> no change.
- Hold iowrite high 10 clks to 3Fh with data changing 01h→00h mid-pulse -> only the first value (romDisable=1, vRamEn=0) latched.
- Assert reset during J1 after one read -> state J0. The next three reads again return C3, 00, F0. romDisable=1 and vRamEn=0 after reset.
- memread high across reset deassertion, then falls -> advances to J1. The following two reads return 00h, F0h.
